qarma_key_sched: RTL

QARMA_KEY_SCHED -- requirements
Module: qarma_key_sched

---
 rtl/qarma_key_sched_if.sv | 31 +++
 rtl/qarma_key_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/qarma_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : qarma_key_sched_if
// Description : Request/result handshake bundle for the QARMA key scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface qarma_key_sched_if #(
    parameter int N = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             enc;
    logic [2*N-1:0]   key;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     w0;
    logic [N-1:0]     w1;
    logic [N-1:0]     k0;
    logic [N-1:0]     k1;

    modport master (
        output in_valid, enc, key, out_ready,
        input  in_ready, out_valid, w0, w1, k0, k1
    );

    modport slave (
        input  in_valid, enc, key, out_ready,
        output in_ready, out_valid, w0, w1, k0, k1
    );
endinterface
`default_nettype wire

// File: rtl/qarma_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : qarma_key_sched
// Description : QARMA key specialisation; MixColumns of the core key is
//               computed one column per cycle for decryption requests.
// Revision    : 1.0 - initial release
// ============================================================================
module qarma_key_sched #(
    parameter int             N     = 64,
    parameter logic [N-1:0]   ALPHA = N'(64'hC0AC29B7C97C50DD)
) (
    input  logic              clk,
    input  logic              rst_n,
    qarma_key_sched_if.slave  bus
);
    localparam int C = N / 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_col;
    logic [N-1:0] r_w0;
    logic [N-1:0] r_w1;
    logic [N-1:0] r_k0;
    logic [C-1:0] r_kc  [16];
    logic [C-1:0] r_k1c [16];

    logic [N-1:0] w_w;
    logic [N-1:0] w_k;
    logic [N-1:0] w_ow;
    logic [N-1:0] w_k1p;
    logic         w_accept;
    logic [C-1:0] w_kcell [16];
    logic [C-1:0] w_cin   [4];
    logic [C-1:0] w_cout  [4];

    function automatic logic [C-1:0] rho1(input logic [C-1:0] x);
        return {x[C-2:0], x[C-1]};
    endfunction

    function automatic logic [C-1:0] rho2(input logic [C-1:0] x);
        return {x[C-3:0], x[C-1:C-2]};
    endfunction

    assign w_w      = bus.key[2*N-1:N];
    assign w_k      = bus.key[N-1:0];
    assign w_ow     = {w_w[0], w_w[N-1:2], w_w[1] ^ w_w[N-1]};
    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.w0        = r_w0;
    assign bus.w1        = r_w1;
    assign bus.k0        = r_k0;
    assign bus.k1        = w_k1p;

    // Cell 0 occupies the most-significant C bits; cell index = 4*row + col.
    always_comb begin
        w_k1p = '0;
        for (int i = 0; i < 16; i++) begin
            w_kcell[i]              = w_k[N-1-i*C -: C];
            w_k1p[N-1-i*C -: C]     = r_k1c[i];
        end
    end

    // One column of circ(0, rho1, rho2, rho1) applied to the captured core key.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [1:0] c_row = 2'(r);
        assign w_cin[r]  = r_kc[{c_row, r_col}];
        assign w_cout[r] = rho1(w_cin[(r+1)%4]) ^ rho2(w_cin[(r+2)%4]) ^ rho1(w_cin[(r+3)%4]);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = bus.enc ? ST_HOLD : ST_MIX;
            ST_MIX:  if (r_col == 2'd3) w_state_nxt = ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= 2'd0;
            r_w0  <= '0;
            r_w1  <= '0;
            r_k0  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_kc[i]  <= '0;
                r_k1c[i] <= '0;
            end
        end else if (w_accept) begin
            r_col <= 2'd0;
            r_w0  <= bus.enc ? w_w : w_ow;
            r_w1  <= bus.enc ? w_ow : w_w;
            r_k0  <= bus.enc ? w_k : (w_k ^ ALPHA);
            for (int i = 0; i < 16; i++) begin
                r_kc[i] <= w_kcell[i];
                if (bus.enc) r_k1c[i] <= w_kcell[i];
            end
        end else if (r_state == ST_MIX) begin
            r_col <= r_col + 2'd1;
            for (int r = 0; r < 4; r++) begin
                r_k1c[{2'(r), r_col}] <= w_cout[r];
            end
        end
    end
endmodule
`default_nettype wire
